// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds the operand width, the step count and the control FSM state type.
package mul_pkg;

   localparam int MUL_WIDTH = 4;
   localparam int MUL_CNT_W = 3;
   localparam int MUL_STEPS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_e;

endpackage

// File: rtl/adder_4bit.sv
// 4-bit ripple-carry adder: {cout, sum} = a + b + cin.
module adder_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   // Ripple the carry bit by bit from the LSB upward.
   always_comb begin
      logic carry_s;
      carry_s = cin;
      sum     = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         sum[i]  = a[i] ^ b[i] ^ carry_s;
         carry_s = (a[i] & b[i]) | (a[i] & carry_s) | (b[i] & carry_s);
      end
      cout = carry_s;
   end

endmodule

// File: rtl/mul_4bit_seq.sv
// Sequential 4x4 unsigned shift-add multiplier with valid/ready on both sides.
// One adder_4bit step per RUN cycle; {hi,lo} shifts right each step so that
// the finished product ends up in {hi,lo}.
// Optional feature macro: MUL_EARLY_EXIT_EN -- finish as soon as the remaining
// multiplier bits are all zero, realigning the partial result with a shift.
module mul_4bit_seq
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH,
   parameter int CNT_W = MUL_CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   if (WIDTH != 4) begin : g_width_chk
      $error("mul_4bit_seq: only WIDTH=4 is supported");
   end
   if ((2 ** CNT_W) < WIDTH) begin : g_cnt_chk
      $error("mul_4bit_seq: CNT_W too narrow to count the steps");
   end

   mul_state_e         state_r, state_nxt_s;
   logic               in_ready_r, busy_r, out_valid_r;
   logic [WIDTH-1:0]   mcand_r, mcand_nxt_s;
   logic [WIDTH-1:0]   hi_r, hi_nxt_s;
   logic [WIDTH-1:0]   lo_r, lo_nxt_s;
   logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
   logic [2*WIDTH-1:0] product_r, product_nxt_s;

   logic [WIDTH-1:0]   addend_s, sum_s, step_hi_s, step_lo_s;
   logic               cout_s, finish_s;
   logic [2*WIDTH-1:0] finish_product_s;

   // The current multiplier LSB selects whether the multiplicand is added.
   assign addend_s = lo_r[0] ? mcand_r : {WIDTH{1'b0}};

   adder_4bit u_adder (
      .a    (hi_r),
      .b    (addend_s),
      .cin  (1'b0),
      .sum  (sum_s),
      .cout (cout_s)
   );

   // The carry is kept in hi's MSB; the sum LSB moves into the top of lo.
   assign step_hi_s = {cout_s, sum_s[WIDTH-1:1]};
   assign step_lo_s = {sum_s[0], lo_r[WIDTH-1:1]};

`ifdef MUL_EARLY_EXIT_EN
   // Unprocessed multiplier bits sit in the low part of lo after the step;
   // shifting the processed ones out leaves zero when nothing is left to add.
   logic [WIDTH-1:0] rest_s;
   assign rest_s           = step_lo_s << (cnt_r + CNT_W'(1));
   assign finish_s         = (rest_s == {WIDTH{1'b0}});
   assign finish_product_s = {step_hi_s, step_lo_s} >> (CNT_W'(MUL_STEPS - 1) - cnt_r);
`else
   assign finish_s         = (cnt_r == CNT_W'(MUL_STEPS - 1));
   assign finish_product_s = {step_hi_s, step_lo_s};
`endif

   // Next-state and datapath update for the IDLE/RUN/DONE control FSM.
   always_comb begin
      state_nxt_s   = state_r;
      mcand_nxt_s   = mcand_r;
      hi_nxt_s      = hi_r;
      lo_nxt_s      = lo_r;
      cnt_nxt_s     = cnt_r;
      product_nxt_s = product_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               mcand_nxt_s = a;
               hi_nxt_s    = {WIDTH{1'b0}};
               lo_nxt_s    = b;
               cnt_nxt_s   = {CNT_W{1'b0}};
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            hi_nxt_s  = step_hi_s;
            lo_nxt_s  = step_lo_s;
            cnt_nxt_s = cnt_r + CNT_W'(1);
            if (finish_s) begin
               product_nxt_s = finish_product_s;
               state_nxt_s   = DONE;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, datapath and registered handshake flags; reset aborts any operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
         out_valid_r <= 1'b0;
         mcand_r     <= {WIDTH{1'b0}};
         hi_r        <= {WIDTH{1'b0}};
         lo_r        <= {WIDTH{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         product_r   <= {(2*WIDTH){1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         in_ready_r  <= (state_nxt_s == IDLE);
         busy_r      <= (state_nxt_s == RUN);
         out_valid_r <= (state_nxt_s == DONE);
         mcand_r     <= mcand_nxt_s;
         hi_r        <= hi_nxt_s;
         lo_r        <= lo_nxt_s;
         cnt_r       <= cnt_nxt_s;
         product_r   <= product_nxt_s;
      end
   end

   assign in_ready  = in_ready_r;
   assign busy      = busy_r;
   assign out_valid = out_valid_r;
   assign product   = product_r;

endmodule
